factorial_ctrl: RTL
===================

FACTORIAL_CTRL -- requirements
Module: factorial_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_ITERS, default 12, giving the MULT-state count at which the watchdog aborts (used only with FACT_CTRL_TIMEOUT_EN).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port go, input, 1, start request; level, held by requester until done or error is seen.
REQ-005 The block SHALL have port a_gt_b, input, 1, datapath flag: down-counter > 1.
REQ-006 The block SHALL have port err, input, 1, datapath flag: operand n > 12.
REQ-007 The block SHALL have ports prod_mux_sel, prod_reg_ld, cnt_ld, cnt_en and out_mux_sel, each output, 1, datapath controls.
REQ-008 The block SHALL have ports busy, done, error and timeout, each output, 1, status.

Function
REQ-009 The FSM SHALL have states IDLE, INIT, CHECK, MULT, DONE and ERROR, held in a registered state vector.
REQ-010 Controls SHALL be Moore decodes of state, with no combinational path from any input to any output.
REQ-011 IDLE: all outputs 0; go=1 -> INIT, else stay.
REQ-012 INIT, 1 cycle: cnt_ld=1, prod_mux_sel=0, prod_reg_ld=1, busy=1 (counter <- n or 1, product <- 1); -> CHECK unconditionally.
REQ-013 CHECK: busy=1, all datapath controls 0; priority err=1 -> ERROR, else a_gt_b=1 -> MULT, else -> DONE.
REQ-014 MULT, 1 cycle: prod_mux_sel=1, prod_reg_ld=1, cnt_en=1, busy=1 (product <- product*count, count--); -> CHECK.
REQ-015 DONE: done=1, out_mux_sel=1, busy=0; stay while go=1; go=0 -> IDLE.
REQ-016 ERROR: error=1, out_mux_sel=0, busy=0; stay while go=1; go=0 -> IDLE.
REQ-017 Latency, with go sampled high in IDLE at edge k: DONE at edge k+2n for 2<=n<=12; DONE at edge k+2 for n<=1; ERROR at edge k+2 for n>12.
REQ-018 Deasserting go while busy SHALL NOT abort the operation; DONE/ERROR is still entered, held one cycle, then the FSM returns to IDLE.
REQ-019 n SHALL be held stable by the requester from go assertion until done or error; the controller does not register n.
REQ-020 Unreachable state encodings SHALL return to IDLE on the next edge with all outputs 0.

Reset
REQ-021 rst=0 SHALL force IDLE immediately, independent of clk, with every output 0 and the iteration counter 0.
REQ-022 Reset asserted in any state, including mid-MULT, SHALL abandon the operation; after release, the FSM waits in IDLE for go.
REQ-023 Release of rst SHALL be synchronized by the system; the block adds no reset synchronizer.

Configuration
REQ-024 The macro FACT_CTRL_TIMEOUT_EN SHALL enable a watchdog.
REQ-025 When defined: a counter (width ceil(log2(TIMEOUT_ITERS+1))) clears in INIT and increments each MULT; in CHECK with err=0, a_gt_b=1 and count==TIMEOUT_ITERS, the FSM goes to ERROR with timeout=1, held for the whole ERROR state.
REQ-026 When undefined: no counter logic, timeout tied 0, and CHECK/MULT loop for as long as a_gt_b=1.

Verification
REQ-027 n=5, go held: cnt_ld pulses once, 4 MULT pulses; done=1 at edge k+10 with factorial_out=120; done holds until go=0, then IDLE.
REQ-028 n=0 and n=1: no MULT pulses; done=1 at edge k+2 with factorial_out=1.
REQ-029 n=13: ERROR at edge k+2; error=1, timeout=0, factorial_out=0; no prod_reg_ld after INIT.
REQ-030 n=12, rst pulled low during the 6th MULT: all outputs 0 asynchronously; after release with go=1, a full run gives 479001600 at edge k+24.
REQ-031 a_gt_b forced 1 and err=0, macro defined: 12 MULT pulses, then error=1 and timeout=1; macro undefined: CHECK/MULT alternate indefinitely and timeout stays 0.
REQ-032 n=5 with go dropped after 1 cycle: run completes, done=1 for exactly 1 cycle at edge k+10, then IDLE.

Source files
------------

// File: rtl/factorial_ctrl.sv
// ---------------------------------------------------------------------------
// factorial_ctrl
//   Moore FSM that sequences an external factorial datapath. The datapath
//   holds a down-counter and a product register. This controller loads both,
//   then alternates CHECK/MULT until the counter reaches 1. It finishes in
//   DONE, or in ERROR when the operand is out of range.
//
//   Every output is a pure decode of the registered state (plus the
//   registered timeout flag), so no input reaches an output combinationally.
//
// Parameters
//   TIMEOUT_ITERS  MULT count at which the watchdog aborts (watchdog builds)
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   asynchronous active-low reset
//   go            in   start request, held by requester until done/error
//   a_gt_b        in   datapath flag: down-counter > 1
//   err           in   datapath flag: operand n > 12
//   prod_mux_sel  out  product mux: 0 = constant 1, 1 = product*count
//   prod_reg_ld   out  product register load
//   cnt_ld        out  down-counter load
//   cnt_en        out  down-counter decrement
//   out_mux_sel   out  result mux: 1 = product, 0 = zero
//   busy          out  operation in progress (INIT/CHECK/MULT)
//   done          out  result valid
//   error         out  operand rejected or watchdog abort
//   timeout       out  ERROR was caused by the watchdog
//
// Build option
//   FACT_CTRL_TIMEOUT_EN  when defined, adds an iteration watchdog that
//                         forces ERROR with timeout=1 after TIMEOUT_ITERS
//                         MULT cycles; when undefined, timeout is tied to 0.
// ---------------------------------------------------------------------------
module factorial_ctrl #(
  parameter int TIMEOUT_ITERS = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic a_gt_b,
  input  logic err,
  output logic prod_mux_sel,
  output logic prod_reg_ld,
  output logic cnt_ld,
  output logic cnt_en,
  output logic out_mux_sel,
  output logic busy,
  output logic done,
  output logic error,
  output logic timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_MULT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0] r_state;
  logic [2:0] w_next_state;

`ifdef FACT_CTRL_TIMEOUT_EN
  localparam int ITER_W = $clog2(TIMEOUT_ITERS + 1);

  logic [ITER_W-1:0] r_iter;
  logic              r_timeout;
  logic              w_expire;

  // The count equals the number of MULT cycles since INIT, so it is
  // compared directly against the limit in CHECK.
  assign w_expire = (r_iter == ITER_W'(TIMEOUT_ITERS));
`endif

  // Next-state logic. Unused encodings fall through to IDLE.
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:  w_next_state = go ? S_INIT : S_IDLE;
      S_INIT:  w_next_state = S_CHECK;
      S_CHECK: begin
        if (err) begin
          w_next_state = S_ERROR;
        end else if (a_gt_b) begin
`ifdef FACT_CTRL_TIMEOUT_EN
          w_next_state = w_expire ? S_ERROR : S_MULT;
`else
          w_next_state = S_MULT;
`endif
        end else begin
          w_next_state = S_DONE;
        end
      end
      S_MULT:  w_next_state = S_CHECK;
      S_DONE:  w_next_state = go ? S_DONE : S_IDLE;
      S_ERROR: w_next_state = go ? S_ERROR : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register. Reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

`ifdef FACT_CTRL_TIMEOUT_EN
  // Watchdog: the count clears in INIT and advances once per MULT. The
  // timeout flag is captured on the CHECK->ERROR decision. It holds for as
  // long as ERROR lasts, so a plain operand error never reports timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iter    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_INIT) begin
        r_iter <= '0;
      end else if (r_state == S_MULT) begin
        r_iter <= r_iter + ITER_W'(1);
      end

      if (r_state == S_CHECK) begin
        r_timeout <= !err && a_gt_b && w_expire;
      end else if (r_state != S_ERROR) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign timeout = (r_state == S_ERROR) && r_timeout;
`else
  // Watchdog compiled out: timeout is a constant 0. The parameter has no
  // effect in this build, because a positive limit always makes the
  // comparison false.
  localparam logic TIMEOUT_TIE = (TIMEOUT_ITERS < 0);

  assign timeout = TIMEOUT_TIE;
`endif

  // Moore output decode. Unreachable encodings leave every output at 0.
  always_comb begin
    prod_mux_sel = 1'b0;
    prod_reg_ld  = 1'b0;
    cnt_ld       = 1'b0;
    cnt_en       = 1'b0;
    out_mux_sel  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    case (r_state)
      S_INIT: begin
        cnt_ld      = 1'b1;
        prod_reg_ld = 1'b1;
        busy        = 1'b1;
      end
      S_CHECK: begin
        busy = 1'b1;
      end
      S_MULT: begin
        prod_mux_sel = 1'b1;
        prod_reg_ld  = 1'b1;
        cnt_en       = 1'b1;
        busy         = 1'b1;
      end
      S_DONE: begin
        done        = 1'b1;
        out_mux_sel = 1'b1;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
